// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   state_t           : fetch FSM states (BOOT / RUN / FAULT)
//   INSTR_W           : instruction word width
//   PC_STEP           : byte distance between consecutive instructions
//   MEM_BYTES_DEFAULT : default instruction memory size in bytes
//   addr_legal()      : word-aligned and inside the memory
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam int          MEM_BYTES_DEFAULT = 400;

  // Unsigned 32-bit compare: a full word at a must lie inside 0..mem_bytes-1.
  function automatic logic addr_legal(input logic [31:0] a, input logic [31:0] mem_bytes);
    return (a[1:0] == 2'b00) && (a <= (mem_bytes - PC_STEP));
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register holding {instr, pc, pc4} plus a valid bit.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears everything)
//   load              : capture instr_d/pc_d/pc4_d and set valid
//   flush             : clear valid (payload left as-is); load wins if both set
//   instr_d/pc_d/pc4_d: payload to capture
//   valid, instr, pc, pc4 : registered contents
// When neither load nor flush is asserted the register holds.
module fetch_unit_ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [31:0]        pc_d,
  input  logic [31:0]        pc4_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
      pc4   <= pc4_d;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: owns the PC, drives the instruction memory read
// address, captures the returned word into the IF/ID register and hands it
// to decode.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_adrs      : memory read address (combinationally the PC register)
//   imem_data      : same-cycle big-endian word at imem_adrs
//   redir_valid/redir_target : branch/jump redirect
//   id_ready       : decode accepts IF/ID this cycle
//   id_valid/id_instr/id_pc/id_pc4 : IF/ID contents
//   fault/fault_pc : in FAULT state / last offending address
//   fetch_cnt      : count of words accepted by decode
//   dbg_state      : current FSM state
//
// Handshake: a word transfers to decode on every rising edge where
// id_valid && id_ready. id_valid never drops without a transfer except on a
// flush (redirect, fault, reset); while id_valid && !id_ready the IF/ID
// contents and the PC are held stable.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_adrs,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redir_valid,
  input  logic [31:0]        redir_target,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               fault,
  output logic [31:0]        fault_pc,
  output logic [CNT_W-1:0]   fetch_cnt,
  output state_t             dbg_state
);

  localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] fault_pc_nx;
  logic        load, flush;
  logic        pc_ok, tgt_ok, advance;

  assign pc_ok   = addr_legal(pc, MEM_SIZE);
  assign tgt_ok  = addr_legal(redir_target, MEM_SIZE);
  // IF/ID can take a new word when it is empty or its word leaves this edge.
  assign advance = !id_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      fault_pc <= fault_pc_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    fault_pc_nx = fault_pc;
    load        = 1'b0;
    flush       = 1'b0;
    unique case (state)
      ST_BOOT: begin
        // One idle cycle to vet the reset PC before the first fetch.
        if (pc_ok) begin
          state_nx = ST_RUN;
        end else begin
          state_nx    = ST_FAULT;
          fault_pc_nx = pc;
        end
      end
      ST_RUN: begin
        if (redir_valid) begin
          // The word on imem_data belongs to the wrong path; never capture it.
          flush = 1'b1;
          if (tgt_ok) begin
            pc_nx = redir_target;
          end else begin
            state_nx    = ST_FAULT;
            fault_pc_nx = redir_target;
          end
        end else if (advance) begin
          if (pc_ok) begin
            load  = 1'b1;
            pc_nx = pc + PC_STEP;
          end else begin
            flush       = 1'b1;
            state_nx    = ST_FAULT;
            fault_pc_nx = pc;
          end
        end
      end
      ST_FAULT: begin
        flush = 1'b1;
        if (redir_valid) begin
          if (tgt_ok) begin
            state_nx = ST_RUN;
            pc_nx    = redir_target;
          end else begin
            fault_pc_nx = redir_target;
          end
        end
      end
      default: begin
        state_nx = ST_FAULT;
        flush    = 1'b1;
      end
    endcase
  end

  // Counts decode's consumption, so a redirect edge still counts the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (id_valid && id_ready) begin
      fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

  fetch_unit_ifid_reg u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .instr_d (imem_data),
    .pc_d    (pc),
    .pc4_d   (pc + PC_STEP),
    .valid   (id_valid),
    .instr   (id_instr),
    .pc      (id_pc),
    .pc4     (id_pc4)
  );

  assign imem_adrs = pc;
  assign fault     = (state == ST_FAULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0] imem_adrs;
  logic [31:0] imem_data;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;
  state_t      dbg_state;

  fetch_unit #(
    .RESET_PC  (32'h0),
    .MEM_BYTES (400),
    .CNT_W     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_adrs    (imem_adrs),
    .imem_data    (imem_data),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc4       (id_pc4),
    .fault        (fault),
    .fault_pc     (fault_pc),
    .fetch_cnt    (fetch_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- memory model (big-endian bytes) ----------------
  logic [7:0] mem [0:399];

  always_comb begin
    if (imem_adrs <= 32'd396)
      imem_data = {mem[imem_adrs], mem[imem_adrs+1], mem[imem_adrs+2], mem[imem_adrs+3]};
    else
      imem_data = 32'hDEAD_BEEF;
  end

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]   = w[31:24];
    mem[a+1] = w[23:16];
    mem[a+2] = w[15:8];
    mem[a+3] = w[7:0];
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change then too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc_e, input logic [31:0] instr_e);
    check({tag, ".valid"}, 32'(id_valid), 32'd1);
    check({tag, ".pc"},    id_pc,         pc_e);
    check({tag, ".pc4"},   id_pc4,        pc_e + 32'd4);
    check({tag, ".instr"}, id_instr,      instr_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 400; i++) mem[i] = 8'(i) ^ 8'h5A;
    put_word(0, 32'h2008_0005);
    put_word(4, 32'h2009_0003);
    put_word(8, 32'h0109_5020);

    id_ready = 1'b1;
    #2;
    // Reset values
    check("rst.valid", 32'(id_valid), 32'd0);
    check("rst.instr", id_instr, 32'd0);
    check("rst.pc",    id_pc, 32'd0);
    check("rst.pc4",   id_pc4, 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.fpc",   fault_pc, 32'd0);
    check("rst.cnt",   fetch_cnt, 32'd0);
    check("rst.adrs",  imem_adrs, 32'd0);
    check("rst.state", 32'(dbg_state), 32'(ST_BOOT));

    @(negedge clk);
    rst_n = 1'b1;

    // BOOT cycle: no fetch
    step();
    check("boot.valid", 32'(id_valid), 32'd0);
    check("boot.adrs",  imem_adrs, 32'd0);
    check("boot.state", 32'(dbg_state), 32'(ST_RUN));

    // Sequential fetch
    step();
    check_id("seq0", 32'h0, 32'h2008_0005);
    check("seq0.cnt", fetch_cnt, 32'd0);
    step();
    check_id("seq1", 32'h4, 32'h2009_0003);
    check("seq1.cnt", fetch_cnt, 32'd1);

    // Stall with id_pc=4 for 3 cycles
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_id("stall", 32'h4, 32'h2009_0003);
      check("stall.adrs", imem_adrs, 32'h8);
      check("stall.cnt", fetch_cnt, 32'd1);
    end
    id_ready = 1'b1;
    step();
    check_id("seq2", 32'h8, 32'h0109_5020);
    check("seq2.cnt", fetch_cnt, 32'd2);
    step();
    check_id("seq3", 32'hC, 32'h5657_5455);
    check("seq3.cnt", fetch_cnt, 32'd3);

    // Redirect to 0x40 while stalled
    id_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h40;
    step();
    check("redir.valid", 32'(id_valid), 32'd0);
    check("redir.adrs",  imem_adrs, 32'h40);
    check("redir.cnt",   fetch_cnt, 32'd3);
    redir_valid = 1'b0;
    id_ready = 1'b1;
    step();
    check_id("redir0", 32'h40, 32'h1A1B_1819);
    check("redir0.cnt", fetch_cnt, 32'd3);
    step();
    check_id("redir1", 32'h44, 32'h1E1F_1C1D);
    check("redir1.cnt", fetch_cnt, 32'd4);

    // Illegal redirects: misaligned, then one past the end
    redir_valid = 1'b1;
    redir_target = 32'h42;
    step();
    check("ill0.fault", 32'(fault), 32'd1);
    check("ill0.fpc",   fault_pc, 32'h42);
    check("ill0.valid", 32'(id_valid), 32'd0);
    check("ill0.adrs",  imem_adrs, 32'h48);
    check("ill0.cnt",   fetch_cnt, 32'd5);
    redir_target = 32'h190;
    step();
    check("ill1.fault", 32'(fault), 32'd1);
    check("ill1.fpc",   fault_pc, 32'h190);
    check("ill1.adrs",  imem_adrs, 32'h48);
    redir_target = 32'h10;
    step();
    check("rec.fault", 32'(fault), 32'd0);
    check("rec.adrs",  imem_adrs, 32'h10);
    check("rec.valid", 32'(id_valid), 32'd0);
    check("rec.fpc",   fault_pc, 32'h190);
    redir_valid = 1'b0;
    step();
    check_id("rec0", 32'h10, 32'h4A4B_4849);
    check("rec0.cnt", fetch_cnt, 32'd5);
    step();
    check_id("rec1", 32'h14, 32'h4E4F_4C4D);
    check("rec1.cnt", fetch_cnt, 32'd6);

    // End of memory: last word delivered, next fetch faults
    redir_valid = 1'b1;
    redir_target = 32'h18C;
    step();
    check("eom.adrs", imem_adrs, 32'h18C);
    check("eom.cnt",  fetch_cnt, 32'd7);
    redir_valid = 1'b0;
    step();
    check_id("eom0", 32'h18C, 32'hD6D7_D4D5);
    check("eom0.adrs", imem_adrs, 32'h190);
    check("eom0.fault", 32'(fault), 32'd0);
    step();
    check("eom1.fault", 32'(fault), 32'd1);
    check("eom1.fpc",   fault_pc, 32'h190);
    check("eom1.valid", 32'(id_valid), 32'd0);
    check("eom1.cnt",   fetch_cnt, 32'd8);
    id_ready = 1'b0;
    step();
    check("eom2.state", 32'(dbg_state), 32'(ST_FAULT));
    check("eom2.adrs",  imem_adrs, 32'h190);
    id_ready = 1'b1;

    // Back to 0, then async reset mid-stream
    redir_valid = 1'b1;
    redir_target = 32'h0;
    step();
    check("r0.fault", 32'(fault), 32'd0);
    redir_valid = 1'b0;
    step();
    check_id("r0", 32'h0, 32'h2008_0005);
    step();
    check_id("r1", 32'h4, 32'h2009_0003);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(id_valid), 32'd0);
    check("arst.pc",    id_pc, 32'd0);
    check("arst.instr", id_instr, 32'd0);
    check("arst.adrs",  imem_adrs, 32'h0);
    check("arst.cnt",   fetch_cnt, 32'd0);
    check("arst.fpc",   fault_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst.boot.valid", 32'(id_valid), 32'd0);
    step();
    check_id("arst.f0", 32'h0, 32'h2008_0005);
    step();
    check_id("arst.f1", 32'h4, 32'h2009_0003);
    check("arst.f1.cnt", fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
